// File: rtl/dcache_miss_ctrl_if.sv
// Pipeline-request and cache-port bundle for the data-cache miss controller.
// slave = controller view, master = pipeline/cache environment view.
interface dcache_miss_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic [31:0] rdata;
  logic        cache_write;
  logic        cache_copy;
  logic        cache_reset;
  logic [15:0] cache_addr;
  logic [31:0] cache_wdata;
  logic        cache_hit;
  logic [31:0] cache_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, flush,
    input  cache_hit, cache_rdata,
    output stall, rdata, cache_write, cache_copy, cache_reset,
    output cache_addr, cache_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, flush,
    output cache_hit, cache_rdata,
    input  stall, rdata, cache_write, cache_copy, cache_reset,
    input  cache_addr, cache_wdata
  );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Hit/miss sequencing, miss-latency wait, fill and flush control for a write-through D-cache.
// Optional hit/miss statistics counters are enabled by defining DCACHE_STATS_EN.
module dcache_miss_ctrl #(
  parameter int MISS_CYCLES = 3
`ifdef DCACHE_STATS_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic clk,
  input  logic reset,
  dcache_miss_ctrl_if.slave bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FILL} state_t;

  localparam logic [3:0] LOAD_CNT = 4'(MISS_CYCLES - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_flush_pend;
  logic       r_copy;

  logic w_idle;
  logic w_flush_now;
  logic w_load;
  logic w_store;
  logic w_miss;

  assign w_idle      = (r_state == S_IDLE) && !reset;
  // A pending flush or a new flush pulse pre-empts any request in this IDLE cycle.
  assign w_flush_now = w_idle && (bus.flush || r_flush_pend);
  assign w_load      = bus.req_valid && !bus.req_write;
  assign w_store     = bus.req_valid && bus.req_write;
  assign w_miss      = w_idle && !w_flush_now && w_load && !bus.cache_hit;

  assign bus.cache_addr  = bus.req_addr;
  assign bus.cache_wdata = bus.req_wdata;
  assign bus.rdata       = bus.cache_rdata;
  assign bus.cache_write = w_idle && !w_flush_now && w_store;
  assign bus.cache_copy  = r_copy && !reset;
  assign bus.cache_reset = reset || w_flush_now;
  assign bus.stall       = !reset &&
                           ((r_state != S_IDLE) || w_miss ||
                            (w_flush_now && (bus.req_valid || r_flush_pend)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_flush_pend <= 1'b0;
      r_copy       <= 1'b0;
    end else begin
      r_copy <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_flush_now) begin
            r_flush_pend <= 1'b0;
          end else if (w_miss) begin
            r_cnt <= LOAD_CNT;
            if (LOAD_CNT == 4'd0) begin
              r_state <= S_FILL;
              r_copy  <= 1'b1;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.flush) r_flush_pend <= 1'b1;
          r_cnt <= (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            r_state <= S_FILL;
            r_copy  <= 1'b1;
          end
        end
        S_FILL: begin
          if (bus.flush) r_flush_pend <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic             w_hit;
  logic             r_after_fill;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  assign w_hit = w_idle && !w_flush_now && w_load && bus.cache_hit;

  // The hit that completes a filled load is not a fresh hit, so it is skipped.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_after_fill <= 1'b0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_after_fill <= (r_state == S_FILL);
      if (w_hit && !r_after_fill && !(&r_hit_cnt)) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
      if (w_miss && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CNT_W'(1);
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl with a behavioural 16-line direct-mapped cache
// and slow memory (mem[a] = 0x5A000000 | a) wrapped around the controller.
module tb_dcache_miss_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_miss_ctrl_if bus();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  dcache_miss_ctrl #(
    .MISS_CYCLES(3)
`ifdef DCACHE_STATS_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  logic [31:0] mem    [0:65535];
  logic [31:0] cdata  [0:15];
  logic [11:0] ctag   [0:15];
  logic        cvalid [0:15];
  int n_cmp  = 0;
  int n_err  = 0;
  int n_copy = 0;

  always_comb begin
    bus.cache_hit   = cvalid[bus.cache_addr[3:0]] && (ctag[bus.cache_addr[3:0]] == bus.cache_addr[15:4]);
    bus.cache_rdata = bus.cache_copy ? mem[bus.cache_addr] : cdata[bus.cache_addr[3:0]];
  end

  always @(posedge clk) begin
    if (bus.cache_reset) begin
      for (int i = 0; i < 16; i++) cvalid[i] <= 1'b0;
    end else if (bus.cache_write) begin
      mem[bus.cache_addr]           <= bus.cache_wdata;
      cdata[bus.cache_addr[3:0]]    <= bus.cache_wdata;
      ctag[bus.cache_addr[3:0]]     <= bus.cache_addr[15:4];
      cvalid[bus.cache_addr[3:0]]   <= 1'b1;
    end else if (bus.cache_copy) begin
      cdata[bus.cache_addr[3:0]]    <= mem[bus.cache_addr];
      ctag[bus.cache_addr[3:0]]     <= bus.cache_addr[15:4];
      cvalid[bus.cache_addr[3:0]]   <= 1'b1;
      n_copy <= n_copy + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [15:0] a,
                       input logic [31:0] d, input logic f);
    bus.req_valid = v;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.flush     = f;
  endtask

  // Entered at a negedge with the load already driven; leaves at negedge+1 of the
  // cycle where stall dropped. Bounded to 20 cycles.
  task automatic finish_load(output int stalls, output int copies, output int copy_at,
                             output logic [31:0] data);
    stalls = 0; copies = 0; copy_at = 0; data = 'x;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!bus.stall) begin
        data = bus.rdata;
        break;
      end
      stalls++;
      if (bus.cache_copy) begin
        copies++;
        copy_at = stalls;
      end
      @(negedge clk);
    end
  endtask

  task automatic load_chk(input string tag, input logic [15:0] a, input int exp_stalls,
                          input logic [31:0] exp_data);
    int stalls, copies, copy_at;
    logic [31:0] data;
    drive(1'b1, 1'b0, a, 32'h0, 1'b0);
    finish_load(stalls, copies, copy_at, data);
    $display("load %h: stalls=%0d copies=%0d data=%h", a, stalls, copies, data);
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, "_copies"}, 32'(copies), (exp_stalls != 0) ? 32'd1 : 32'd0);
    chk({tag, "_copy_at"}, 32'(copy_at), 32'(exp_stalls));
    chk({tag, "_data"}, data, exp_data);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int stalls, copies, copy_at, c0;
    logic [31:0] data;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);

    // Reset state
    @(negedge clk); #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_cache_reset", bus.cache_reset, 1);
    chk("rst_copy", bus.cache_copy, 0);
    chk("rst_write", bus.cache_write, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("idle_cache_reset", bus.cache_reset, 0);
    chk("idle_stall", bus.stall, 0);
    @(negedge clk);

    // Read miss then hit
    load_chk("miss_0012", 16'h0012, 4, 32'h5A00_0012);
    load_chk("hit_0012", 16'h0012, 0, 32'h5A00_0012);

    // Store then load back
    drive(1'b1, 1'b1, 16'h0035, 32'hDEAD_BEEF, 1'b0);
    #1;
    $display("store %h <= %h", bus.req_addr, bus.req_wdata);
    chk("st_write", bus.cache_write, 1);
    chk("st_stall", bus.stall, 0);
    chk("st_copy", bus.cache_copy, 0);
    chk("st_addr", bus.cache_addr, 32'h0035);
    chk("st_wdata", bus.cache_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #1;
    chk("st_write_once", bus.cache_write, 0);
    @(negedge clk);
    load_chk("hit_0035", 16'h0035, 0, 32'hDEAD_BEEF);

    // Conflict on index 2
    load_chk("miss_0112", 16'h0112, 4, 32'h5A00_0112);
    load_chk("remiss_0012", 16'h0012, 4, 32'h5A00_0012);

    // Flush with no request
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    #1;
    $display("flush idle");
    chk("fl_cache_reset", bus.cache_reset, 1);
    chk("fl_stall", bus.stall, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #1;
    chk("fl_once", bus.cache_reset, 0);
    @(negedge clk);

    // Flush concurrent with a store: flush wins, store retried next cycle
    drive(1'b1, 1'b1, 16'h0036, 32'h1234_5678, 1'b1);
    #1;
    $display("flush + store %h", bus.req_addr);
    chk("fs_stall", bus.stall, 1);
    chk("fs_write", bus.cache_write, 0);
    chk("fs_cache_reset", bus.cache_reset, 1);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("fs2_write", bus.cache_write, 1);
    chk("fs2_stall", bus.stall, 0);
    chk("fs2_cache_reset", bus.cache_reset, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    load_chk("hit_0036", 16'h0036, 0, 32'h1234_5678);

    // Reset during the second WAIT cycle
    load_chk("miss_0012b", 16'h0012, 4, 32'h5A00_0012);
    c0 = n_copy;
    drive(1'b1, 1'b0, 16'h0020, 32'h0, 1'b0);
    #1;
    $display("load %h interrupted by reset", bus.req_addr);
    chk("rm_miss_stall", bus.stall, 1);
    @(negedge clk); #1;
    chk("rm_wait1_stall", bus.stall, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rm_rst_copy", bus.cache_copy, 0);
    chk("rm_rst_stall", bus.stall, 0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #1;
    chk("rm_after_stall", bus.stall, 0);
    chk("rm_after_copy", bus.cache_copy, 0);
    chk("rm_no_fill", 32'(n_copy), 32'(c0));
    @(negedge clk);
    load_chk("rm_invalid_0012", 16'h0012, 4, 32'h5A00_0012);

    // Flush pulsed during FILL: executed in next IDLE cycle, line is then gone
    drive(1'b1, 1'b0, 16'h0040, 32'h0, 1'b0);
    $display("load %h with flush during fill", bus.req_addr);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ff_pre_stall", bus.stall, 1);
      chk("ff_pre_copy", bus.cache_copy, 0);
      @(negedge clk);
    end
    bus.flush = 1'b1;
    #1;
    chk("ff_copy", bus.cache_copy, 1);
    chk("ff_stall", bus.stall, 1);
    chk("ff_no_reset_yet", bus.cache_reset, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("ff_pend_cache_reset", bus.cache_reset, 1);
    chk("ff_pend_stall", bus.stall, 1);
    chk("ff_pend_copy", bus.cache_copy, 0);
    @(negedge clk); #1;
    chk("ff_remiss_stall", bus.stall, 1);
    chk("ff_remiss_cache_reset", bus.cache_reset, 0);
    @(negedge clk);
    finish_load(stalls, copies, copy_at, data);
    chk("ff_rest_stalls", 32'(stalls), 3);
    chk("ff_rest_copies", 32'(copies), 1);
    chk("ff_rest_data", data, 32'h5A00_0040);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    load_chk("hit_0040", 16'h0040, 0, 32'h5A00_0040);

`ifdef DCACHE_STATS_EN
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("st_hit_rst", hit_count, 0);
    chk("st_miss_rst", miss_count, 0);
    @(negedge clk);
    load_chk("st_m0", 16'h0100, 4, 32'h5A00_0100);
    load_chk("st_m1", 16'h0101, 4, 32'h5A00_0101);
    load_chk("st_m2", 16'h0102, 4, 32'h5A00_0102);
    load_chk("st_h0", 16'h0100, 0, 32'h5A00_0100);
    load_chk("st_h1", 16'h0101, 0, 32'h5A00_0101);
    load_chk("st_h2", 16'h0102, 0, 32'h5A00_0102);
    load_chk("st_h3", 16'h0100, 0, 32'h5A00_0100);
    load_chk("st_h4", 16'h0101, 0, 32'h5A00_0101);
    #1;
    chk("st_miss_count", miss_count, 3);
    chk("st_hit_count", hit_count, 5);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 32'h0, 1'b0);
    #1;
    chk("st_miss_after_flush", miss_count, 3);
    chk("st_hit_after_flush", hit_count, 5);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Sequences the 16-entry direct-mapped, write-through data cache and its backing slow memory for the pipelined CPU's MEM stage.
- Decides hit/miss for each MEM-stage access and stalls the pipeline on read misses.
- Waits out the memory access latency, then issues the cache fill (copy) and returns the filled word.
- Also drives cache invalidation on reset and on an explicit flush request.

Parameters:
- MISS_CYCLES, 3, clock cycles waited after a read miss before the fill cycle; covers the 22 ns memory delay at a 10 ns clock. Legal range 1..15.
- CNT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  MEM stage has a load or store this cycle
- req_write  in  1  1 = store, 0 = load
- req_addr  in  16  word address
- req_wdata  in  32  store data
- flush  in  1  invalidate the whole cache (single-cycle pulse)
- stall  out  1  freeze pipeline stages IF..MEM
- rdata  out  32  load result, valid when req_valid & ~req_write & ~stall
- cache_write  out  1  to cache write port (writes cache and memory)
- cache_copy  out  1  to cache copy port (fill from memory)
- cache_reset  out  1  to cache reset (invalidate all lines)
- cache_addr  out  16  to cache address
- cache_wdata  out  32  to cache write data
- cache_hit  in  1  from cache hit
- cache_rdata  in  32  from cache read data (memory data while cache_copy is high)

Behaviour:
- Interface: reset is `reset`, synchronous, active-high; clock is `clk`.
- Reset values:
  - state = IDLE, wait counter = 0.
  - stall = 0, cache_write = 0, cache_copy = 0.
  - cache_reset = 1 during every cycle reset is high.
- Pass-through: cache_addr = req_addr and cache_wdata = req_wdata at all times. The pipeline holds the request stable while stall = 1.
- State IDLE:
  - Store (req_valid & req_write): cache_write = 1 combinationally; completes in the same cycle; stall = 0; stays in IDLE.
  - Load hit (req_valid & ~req_write & cache_hit): rdata = cache_rdata; stall = 0; zero added latency.
  - Load miss (req_valid & ~req_write & ~cache_hit): stall = 1 combinationally; counter loads MISS_CYCLES-1; next state is WAIT.
  - ~req_valid: no cache strobes asserted.
- State WAIT:
  - stall = 1.
  - Counter decrements each cycle; when it reaches 0 the next state is FILL.
  - Total cycles from the miss cycle to FILL = MISS_CYCLES.
- State FILL:
  - cache_copy = 1 and stall = 1 for exactly one cycle.
  - rdata = cache_rdata (memory data).
  - Next state is IDLE. In the following cycle the load re-evaluates as a hit, drops stall and returns rdata.
- Read-miss latency: the stall is high for MISS_CYCLES+1 cycles.
- Only one outstanding miss at a time.
- cache_write is never asserted outside IDLE, and never in the same cycle as cache_copy.
- Flush:
  - In IDLE with no request: cache_reset = 1 for one cycle.
  - flush concurrent with a request in IDLE: the flush has priority; stall = 1 for that cycle and the request is re-evaluated next cycle.
  - flush during WAIT or FILL: held pending (1-bit latch) and executed in the first IDLE cycle, with stall = 1 that cycle.
- Reset mid-miss: returns to IDLE immediately, no cache_copy is issued, the pending flush is cleared, and stall = 0 on the next cycle.
- Counter rules: the counter never wraps below 0. With MISS_CYCLES = 1, WAIT lasts zero cycles and the FSM goes straight to FILL.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- When defined, adds outputs hit_count and miss_count (CNT_W each):
  - Both are cleared by reset; flush does not clear them.
  - hit_count increments once per completed load hit, excluding the re-evaluation cycle after a fill.
  - miss_count increments once per miss, on entry to WAIT/FILL.
  - Both saturate at all-ones.
- When undefined, the ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Reset, then load from addr 0x0012 -> miss; stall high for 4 cycles (MISS_CYCLES = 3); cache_copy pulses once in cycle 4; rdata = mem[0x0012]; repeat the load -> hit with stall = 0.
- Store 0xDEADBEEF to 0x0035, then load 0x0035 -> cache_write pulses 1 cycle with no stall; the load hits and returns 0xDEADBEEF.
- Load 0x0012 (fill), then load 0x0112 (same index, different tag) -> second load misses and refills; a later load of 0x0012 misses again.
- Assert reset in WAIT cycle 2 -> no cache_copy; stall = 0 after reset; all lines invalid (a load of a previously filled address misses).
- Pulse flush during FILL -> cache_reset asserted in the next IDLE cycle with stall = 1; a subsequent load of the just-filled address misses.
- With DCACHE_STATS_EN: 3 misses, then 5 hits -> miss_count = 3, hit_count = 5; flush leaves both unchanged.
